serial_alu: RTL and testbench
=============================

# serial_alu

Bit-serial 8-bit add/subtract/XOR/compare unit for the 8-bit CPU emulator. It is built directly downstream of the TTL XOR operand-inversion stage. Per bit, it applies the same conditional inversion of B (XOR with the subtract line) and feeds the result into a one-bit full adder with a carry flip-flop. It processes one bit per clock, least-significant bit first. It is an alternative to the parallel ripple-adder datapath for the ALU.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is 2..16.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new operation. Accepted only when `busy`=0.
- `op`  in  2: operation select. 00 ADD, 01 SUB, 10 XOR, 11 CMP.
- `a`  in  WIDTH: operand A. Sampled only on an accepted `start`.
- `b`  in  WIDTH: operand B. Sampled only on an accepted `start`.
- `busy`  out  1: high while state is RUN.
- `done`  out  1: one-cycle pulse when results become valid.
- `result`  out  WIDTH: registered result.
- `flag_c`, `flag_z`, `flag_n`, `flag_v`  out  1 each: carry, zero, negative, overflow.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE to RUN on `start`.
  - RUN to DONE after WIDTH bit steps.
  - DONE to RUN if `start` is high, otherwise DONE to IDLE.
- On an accepted `start`:
  - Load `a` and `b` into internal shift registers.
  - Latch `op`.
  - Clear the bit counter.
  - Preset carry to 1 for SUB/CMP (two's complement via inverted B), and to 0 for ADD/XOR.
- RUN bit step, per edge:
  - `bi = b[0] ^ inv`, where `inv` = (op is SUB or CMP).
  - `s = a[0] ^ bi ^ c`.
  - `c' = maj(a[0], bi, c)`.
  - For XOR, `s = a[0] ^ b[0]` and the carry is not updated.
  - Shift `s` into the MSB of the staging register. Shift A and B right. Increment the counter.
  - Record the carry-in of the MSB step for overflow.
- On the edge that completes bit WIDTH-1, update the outputs:
  - `result` takes the staged value, except for CMP, where `result` holds its previous value.
  - `flag_c` is the final carry. For SUB/CMP, 1 means no borrow. For XOR it is 0.
  - `flag_z` is 1 if the staged value is all zeros (for CMP, this is the discarded difference).
  - `flag_n` is the staged MSB.
  - `flag_v` is the carry into the MSB XOR the carry out of the MSB. For XOR it is 0.
- `result` and the flags hold their values in every other cycle.
- `start` while `busy`=1 is ignored. Operand and `op` changes during RUN have no effect.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, all flags 0, counter 0, shift registers 0.
- Reset during RUN aborts the operation. No `done` is produced and the outputs go to their reset values.

## Timing
- `start` is sampled high at edge E0. After E0, `busy`=1.
- Bit steps occur at edges E1..E(WIDTH).
- After E(WIDTH): state DONE, `busy`=0, `done`=1, outputs valid. Latency is WIDTH edges from the accepting edge.
- `done` lasts exactly one cycle.
- Back-to-back operation: `start` high during DONE is accepted at E(WIDTH+1), giving a throughput of one operation per WIDTH+1 cycles.
- `busy` and `done` are never high together. Both are registered and glitch-free.

## Structure
- Shared package `serial_alu_pkg` holds:
  - the op encodings OP_ADD, OP_SUB, OP_XOR, OP_CMP;
  - the state encodings ST_IDLE, ST_RUN, ST_DONE;
  - the counter width, defined as clog2(WIDTH+1).
- Sub-module `serial_adder_cell` is the one-bit XOR-based full adder plus carry flip-flop. It has inputs for inversion, XOR-only mode, carry preset, and enable. It uses the same asynchronous active-low reset.
- The top level contains the FSM, the counter, the shift registers, the output registers, and the flag logic.

## Test plan
- ADD a=0x3C, b=0x5A:
  - `busy` high for 8 cycles, then `done` pulse.
  - `result`=0x96, C0 Z0 N1 V1.
- SUB a=0x10, b=0x10: `result`=0x00, C1 Z1 N0 V0.
- SUB a=0x00, b=0x01: `result`=0xFF, C0 Z0 N1 V0.
- XOR a=0xA5, b=0xFF: `result`=0x5A, C0 Z0 N0 V0.
- CMP a=0x80, b=0x01 with prior `result`=0x5A:
  - `result` stays 0x5A.
  - Flags from 0x7F: C1 Z0 N0 V1.
- Control and boundary checks:
  - Pulse `start` at RUN cycle 3: ignored; result unaffected.
  - Assert `rst_n`=0 at RUN cycle 4: all outputs 0 immediately; no `done`.
  - Hold `start` through DONE: second operation accepted with no IDLE cycle; `done` pulses 9 cycles apart.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared encodings and sizing helpers for the bit-serial ALU.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_cell.sv
// One-bit full adder with optional B inversion, XOR-only mode
// and a presettable carry flip-flop.
module serial_adder_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic b_i,
  input  logic inv_i,
  input  logic xor_i,
  input  logic load_i,
  input  logic preset_i,
  input  logic en_i,
  output logic s_o,
  output logic c_o,
  output logic co_o
);

  logic c_q, c_d, bi;

  assign bi   = b_i ^ inv_i;
  assign co_o = (a_i & bi) | (a_i & c_q) | (bi & c_q);
  assign s_o  = xor_i ? (a_i ^ b_i) : (a_i ^ bi ^ c_q);
  assign c_o  = c_q;

  always_comb begin
    c_d = c_q;
    if (load_i)
      c_d = preset_i;
    else if (en_i && !xor_i)
      c_d = co_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= 1'b0;
    else        c_q <= c_d;
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial add/sub/xor/compare unit, LSB first, one bit per clock.
// Results and flags update on the step that consumes the MSB.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] stg_q, stg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept, step, last;
  logic             is_inv, is_xor, preset;
  logic             s, c_cur, c_nxt;
  logic [WIDTH-1:0] stg_nx;

  assign op_in  = op_e'(op);
  assign accept = start && (state_q != ST_RUN);
  assign step   = (state_q == ST_RUN);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign stg_nx = {s, stg_q[WIDTH-1:1]};

  assign is_inv = (op_q == OP_SUB) || (op_q == OP_CMP);
  assign is_xor = (op_q == OP_XOR);
  assign preset = (op_in == OP_SUB) || (op_in == OP_CMP);

  serial_adder_cell u_cell (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_i      (a_q[0]),
    .b_i      (b_q[0]),
    .inv_i    (is_inv),
    .xor_i    (is_xor),
    .load_i   (accept),
    .preset_i (preset),
    .en_i     (step),
    .s_o      (s),
    .c_o      (c_cur),
    .co_o     (c_nxt)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    stg_d   = stg_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          op_d    = op_in;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          stg_d   = '0;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        stg_d = stg_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = ST_DONE;
          res_d   = (op_q == OP_CMP) ? res_q : stg_nx;
          // c_cur is the carry into the MSB at this step
          flg_d = {is_xor ? 1'b0 : c_nxt,
                   (stg_nx == '0),
                   s,
                   is_xor ? 1'b0 : (c_cur ^ c_nxt)};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      stg_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stg_q   <= stg_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign flag_c = flg_q[3];
  assign flag_z = flg_q[2];
  assign flag_n = flg_q[1];
  assign flag_v = flg_q[0];

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: expectations are queued at
// issue time and checked against every done pulse.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic         flag_c, flag_z, flag_n, flag_v;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           ndone = 0;
  logic [W-1:0] model_res = '0;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_model(input logic [1:0] o,
                                     input logic [W-1:0] x,
                                     input logic [W-1:0] y);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c, v;
    exp_t         e;
    if (o == 2'b10) begin
      r = x ^ y;
      c = 1'b0;
      v = 1'b0;
    end else if (o == 2'b00) begin
      sum = {1'b0, x} + {1'b0, y};
      r   = sum[W-1:0];
      c   = sum[W];
      v   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      sum = {1'b0, x} + {1'b0, ~y} + 1;
      r   = sum[W-1:0];
      c   = sum[W];
      v   = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    e.f = {c, (r == '0), r[W-1], v};
    e.r = (o == 2'b11) ? model_res : r;
    model_res = e.r;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) chk("busy_done_excl", {31'b0, busy & done}, 0);
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result", {24'b0, result}, {24'b0, e.r});
        chk("flags_czn v", {28'b0, flag_c, flag_z, flag_n, flag_v},
            {28'b0, e.f});
      end
    end
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'b0, done}, 1);
  endtask

  // glitch: busy cycle on which a stray start is pulsed (0 = none)
  // rst_at: busy cycle on which reset is asserted (0 = none)
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int glitch,
                       input int rst_at);
    int k = 0;
    int nd;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    while (busy && k < 100) begin
      k++;
      start = (k == glitch);
      if (k == glitch) begin
        op = 2'b10; a = W'($urandom); b = W'($urandom);
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_result", {24'b0, result}, 0);
        chk("rst_flags", {28'b0, flag_c, flag_z, flag_n, flag_v}, 0);
        chk("rst_busy_done", {30'b0, busy, done}, 0);
        void'(sb.pop_back());
        model_res = '0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (rst_at > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      nd = ndone;
      repeat (12) @(negedge clk);
      chk("no_done_after_rst", nd, ndone);
      chk("idle_after_rst", {31'b0, busy}, 0);
    end else begin
      chk("busy_cycles", k, W);
      chk("done_pulse", {31'b0, done}, 1);
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 0);
      if (glitch > 0) begin
        nd = ndone;
        repeat (12) @(negedge clk);
        chk("glitch_no_extra", nd, ndone);
      end
    end
  endtask

  vec_t vt[5];

  initial begin
    int d1;
    vt[0] = '{2'b00, 8'h3C, 8'h5A, 8'h96, 4'b0011};
    vt[1] = '{2'b01, 8'h10, 8'h10, 8'h00, 4'b1100};
    vt[2] = '{2'b01, 8'h00, 8'h01, 8'hFF, 4'b0010};
    vt[3] = '{2'b10, 8'hA5, 8'hFF, 8'h5A, 4'b0000};
    vt[4] = '{2'b11, 8'h80, 8'h01, 8'h5A, 4'b1001};

    repeat (3) @(negedge clk);
    chk("reset_result", {24'b0, result}, 0);
    chk("reset_flags", {28'b0, flag_c, flag_z, flag_n, flag_v}, 0);
    chk("reset_busy_done", {30'b0, busy, done}, 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      sb.push_back('{vt[i].r, vt[i].f});
      model_res = vt[i].r;
      do_op(vt[i].o, vt[i].x, vt[i].y, 0, 0);
    end

    push_model(2'b00, 8'h7F, 8'h01);
    do_op(2'b00, 8'h7F, 8'h01, 3, 0);

    push_model(2'b01, 8'h44, 8'h12);
    do_op(2'b01, 8'h44, 8'h12, 0, 4);

    push_model(2'b00, 8'hFF, 8'h01);
    push_model(2'b01, 8'h05, 8'h09);
    @(negedge clk);
    op = 2'b00; a = 8'hFF; b = 8'h01; start = 1'b1;
    @(negedge clk);
    op = 2'b01; a = 8'h05; b = 8'h09;
    wait_done();
    d1 = cyc;
    @(negedge clk);
    chk("b2b_no_idle", {31'b0, busy}, 1);
    start = 1'b0;
    wait_done();
    chk("b2b_gap", cyc - d1, W + 1);

    for (int i = 0; i < 10; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      push_model(o, x, y);
      do_op(o, x, y, 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
